tx_interface: RTL and testbench
===============================

Name: tx_interface

Overview:
Return-path sequencer between the ALU result and tx_uart.
- Captures each completed ALU result on a valid strobe and buffers it in a small FIFO.
- Hands bytes to tx_uart one at a time: pulses o_tx_start, then waits for tx_uart's done tick before releasing the next byte.
- Complements the receive-side interface block, so every computed result is echoed back over the serial line.

Parameters:
NB_DATA, 8, width of result byte / UART data
FIFO_DEPTH, 4, number of buffered results (power of two)
NB_PTR, 2, pointer width = log2(FIFO_DEPTH)

Ports:
i_clock  input  1  system clock; all logic on rising edge
i_reset  input  1  synchronous, active-high reset
i_valid  input  1  one-cycle strobe: i_result holds a new result to send
i_result  input  NB_DATA  ALU result byte
i_tx_done_tick  input  1  one-cycle pulse from tx_uart: frame (stop bit) finished
o_tx_start  output  1  one-cycle pulse to tx_uart: start transmitting o_data
o_data  output  NB_DATA  byte presented to tx_uart; held stable until next load
o_busy  output  1  high while state = WAIT_DONE
o_full  output  1  FIFO count == FIFO_DEPTH
o_overflow  output  1  sticky: a push was dropped because FIFO was full

Behaviour:
- Reset (synchronous, sampled on rising edge with i_reset=1):
  - state=IDLE; wr_ptr=rd_ptr=0; count=0 (width NB_PTR+1).
  - o_tx_start=0, o_data=0, o_busy=0, o_full=0, o_overflow=0.
  - Reset mid-transfer abandons the current byte and all buffered bytes; a later i_tx_done_tick is ignored while in IDLE.
- Push:
  - When i_valid=1 and count<FIFO_DEPTH (evaluated on pre-edge count), i_result is written at wr_ptr; wr_ptr increments, wrapping FIFO_DEPTH-1 -> 0.
  - When i_valid=1 and count==FIFO_DEPTH, the byte is dropped and o_overflow is set. This holds even if a pop occurs in the same cycle.
  - o_overflow clears only on reset.
- FSM, two states:
  - IDLE:
    - If count>0 (pre-edge): o_data<=fifo[rd_ptr]; rd_ptr increments with wrap; o_tx_start<=1 for exactly one cycle; next state WAIT_DONE.
    - Otherwise stay in IDLE with o_tx_start=0.
    - i_tx_done_tick is ignored in IDLE.
  - WAIT_DONE:
    - o_busy=1; o_tx_start=0.
    - On i_tx_done_tick=1, return to IDLE.
    - The next byte (if any) starts one cycle later: there is a one-cycle IDLE gap between consecutive o_tx_start pulses.
- Count update:
  - Push only: +1. Pop only: -1. Push and pop in the same cycle: unchanged.
  - count never exceeds FIFO_DEPTH and never underflows.
- Latency: with FIFO empty and FSM in IDLE, i_valid in cycle N causes o_tx_start=1 in cycle N+2, with o_data = that byte.
- Push into an empty FIFO is not bypassed to the same-cycle pop.
- o_full is combinational from count.
- o_data holds the last sent byte until the next load.
- Ordering is strict FIFO.

Test Plan:
- Reset then idle 20 cycles -> o_tx_start never asserted; o_data=0x00; o_busy=0; o_full=0; o_overflow=0.
- Single push 0xA5 at cycle N -> o_tx_start high only in N+2 with o_data=0xA5; o_busy high from N+2 until done tick; o_data stays 0xA5 afterward.
- Burst of pushes 0x01,0x02,0x03 on consecutive cycles, done tick 10 cycles after each start -> three start pulses in order 0x01,0x02,0x03, each one cycle after the prior done tick is consumed in IDLE; o_overflow=0.
- With done ticks withheld, push 6 bytes 0x10..0x15 -> first byte (0x10) is popped into o_data, FIFO fills with 0x11..0x14, o_full=1 after the 5th push, 0x15 dropped, o_overflow=1. Release done ticks -> 0x11,0x12,0x13,0x14 transmitted; o_overflow stays 1.
- Full FIFO with push and FSM pop in the same cycle -> pushed byte dropped, o_overflow set, count decreases by 1.
- Assert i_reset while in WAIT_DONE with 2 buffered bytes, then pulse i_tx_done_tick -> no further o_tx_start; count=0; o_overflow=0. A new push 0x7E then transmits normally.
- Spurious i_tx_done_tick in IDLE with FIFO empty -> no state change and no o_tx_start.

Source files
------------

// File: rtl/tx_interface.sv
// Return-path sequencer: buffers ALU results in a small FIFO and feeds them
// to tx_uart one frame at a time, waiting for the done tick between bytes.
module tx_interface #(
    parameter int NB_DATA    = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int NB_PTR     = 2
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_result,
    input  logic               i_tx_done_tick,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_busy,
    output logic               o_full,
    output logic               o_overflow
);

    // state     | meaning
    // IDLE      | no frame in flight; loads next byte when FIFO not empty
    // WAIT_DONE | frame handed to tx_uart; waiting for its done tick
    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_DONE = 1'b1
    } state_t;

    localparam logic [NB_PTR:0] DEPTH = (NB_PTR + 1)'(FIFO_DEPTH);

    state_t              state;
    state_t              next_state;
    logic [NB_PTR-1:0]   wr_ptr;
    logic [NB_PTR-1:0]   rd_ptr;
    logic [NB_PTR:0]     count;
    logic [NB_DATA-1:0]  mem [FIFO_DEPTH];
    logic                push;
    logic                pop;
    logic                drop;

    // Full-FIFO pushes are dropped even when a pop frees a slot on the same edge.
    assign push   = i_valid && (count < DEPTH);
    assign drop   = i_valid && (count == DEPTH);
    assign o_full = (count == DEPTH);
    assign o_busy = (state == WAIT_DONE);

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    next_state = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (i_tx_done_tick) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge i_clock) begin
        if (push) begin
            mem[wr_ptr] <= i_result;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_tx_start <= 1'b0;
            o_data     <= '0;
            o_overflow <= 1'b0;
        end else begin
            o_tx_start <= pop;
            if (push) begin
                wr_ptr <= wr_ptr + NB_PTR'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + NB_PTR'(1);
                o_data <= mem[rd_ptr];
            end
            if (drop) begin
                o_overflow <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + (NB_PTR + 1)'(1);
                2'b01:   count <= count - (NB_PTR + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_interface.sv
// Bench for tx_interface: cycle table for the single-byte path plus
// scoreboarded bursts, overflow, reset-abandon and full push/pop collision.
module tb_tx_interface;

    logic       i_clock = 1'b0;
    logic       i_reset;
    logic       i_valid;
    logic [7:0] i_result;
    logic       i_tx_done_tick;
    logic       o_tx_start;
    logic [7:0] o_data;
    logic       o_busy;
    logic       o_full;
    logic       o_overflow;

    tx_interface #(.NB_DATA(8), .FIFO_DEPTH(4), .NB_PTR(2)) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_valid       (i_valid),
        .i_result      (i_result),
        .i_tx_done_tick(i_tx_done_tick),
        .o_tx_start    (o_tx_start),
        .o_data        (o_data),
        .o_busy        (o_busy),
        .o_full        (o_full),
        .o_overflow    (o_overflow)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        logic       valid;
        logic [7:0] result;
        logic       done;
        logic       start;
        logic [7:0] data;
        logic       busy;
        logic       full;
        logic       ovf;
    } vec_t;

    vec_t       tbl [9];
    logic [7:0] exp_q [$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         start_count = 0;
    int         done_count = 0;
    int         last_done_cyc = 0;
    logic       gap_armed = 1'b0;
    int         s0;

    always @(posedge i_clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic chk_outs(input string name, input logic [11:0] exp);
        chk(name, {20'd0, o_tx_start, o_data, o_busy, o_full, o_overflow}, {20'd0, exp});
    endtask

    // Scoreboard: every start pulse must carry the oldest expected byte.
    always @(negedge i_clock) begin
        if (o_tx_start === 1'b1) begin
            start_count++;
            if (gap_armed) begin
                chk("start_gap", cyc, last_done_cyc + 2);
                gap_armed = 1'b0;
            end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_start: data=0x%0h, required no start (cycle %0d)", o_data, cyc);
            end else begin
                chk("tx_byte", {24'd0, o_data}, {24'd0, exp_q.pop_front()});
            end
            chk("busy_at_start", {31'd0, o_busy}, 32'd1);
        end
    end

    // tx_uart stand-in: answers each outstanding start with a done tick.
    task automatic serve(input int n, input int dly);
        for (int f = 0; f < n; f++) begin
            int w = 0;
            while (start_count <= done_count && w < 60) begin
                tick();
                w++;
            end
            if (start_count <= done_count) begin
                checks++;
                errors++;
                $display("FAIL serve_timeout: starts=%0d, required more than %0d", start_count, done_count);
                return;
            end
            repeat (dly) tick();
            i_tx_done_tick = 1'b1;
            last_done_cyc  = cyc;
            gap_armed      = (f < n - 1);
            tick();
            i_tx_done_tick = 1'b0;
            done_count++;
        end
    endtask

    task automatic push_seq(input logic [7:0] first, input int n);
        for (int k = 0; k < n; k++) begin
            i_valid  = 1'b1;
            i_result = first + 8'(k);
            tick();
        end
        i_valid = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1; i_valid = 1'b0; i_result = 8'h00; i_tx_done_tick = 1'b0;
        repeat (3) tick();
        i_reset = 1'b0;

        for (int k = 0; k < 20; k++) begin
            chk_outs("idle_after_reset", 12'h000);
            tick();
        end
        chk("idle_no_start", start_count, 0);

        //            valid  result  done  start data   busy full ovf
        tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 9; k++) begin
            i_valid        = tbl[k].valid;
            i_result       = tbl[k].result;
            i_tx_done_tick = tbl[k].done;
            if (tbl[k].valid) exp_q.push_back(tbl[k].result);
            chk_outs($sformatf("table_row%0d", k),
                     {tbl[k].start, tbl[k].data, tbl[k].busy, tbl[k].full, tbl[k].ovf});
            tick();
        end
        i_valid = 1'b0; i_tx_done_tick = 1'b0;
        done_count = 1;
        chk("table_starts", start_count, 1);

        // Burst of three, done tick ten cycles after each start.
        for (int k = 1; k <= 3; k++) exp_q.push_back(8'(k));
        push_seq(8'h01, 3);
        serve(3, 10);
        repeat (3) tick();
        chk("burst_starts", start_count, 4);
        chk_outs("burst_end", {1'b0, 8'h03, 1'b0, 1'b0, 1'b0});

        // Fill with done withheld: 0x10 in flight, 0x11..0x14 buffered, 0x15 dropped.
        for (int k = 0; k < 5; k++) exp_q.push_back(8'h10 + 8'(k));
        push_seq(8'h10, 5);
        chk("fill_full", {31'd0, o_full}, 32'd1);
        chk("fill_no_ovf", {31'd0, o_overflow}, 32'd0);
        i_valid = 1'b1; i_result = 8'h15;
        tick();
        i_valid = 1'b0;
        chk("fill_ovf_set", {31'd0, o_overflow}, 32'd1);
        chk("fill_data_first", {24'd0, o_data}, 32'h10);
        serve(5, 3);
        repeat (3) tick();
        chk("fill_starts", start_count, 9);
        chk_outs("fill_end", {1'b0, 8'h14, 1'b0, 1'b0, 1'b1});

        // Reset in WAIT_DONE with two bytes buffered, then a stray done tick.
        s0 = start_count;
        exp_q.push_back(8'h30);
        push_seq(8'h30, 3);
        chk("rst_in_flight", start_count, s0 + 1);
        chk("rst_busy_before", {31'd0, o_busy}, 32'd1);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        chk_outs("rst_outputs", 12'h000);
        i_tx_done_tick = 1'b1;
        tick();
        i_tx_done_tick = 1'b0;
        repeat (10) tick();
        chk("rst_no_more_starts", start_count, s0 + 1);
        chk_outs("rst_quiet", 12'h000);
        done_count = start_count;
        exp_q.push_back(8'h7E);
        i_valid = 1'b1; i_result = 8'h7E;
        tick();
        i_valid = 1'b0;
        tick();
        chk_outs("rst_then_7e", {1'b1, 8'h7E, 1'b1, 1'b0, 1'b0});
        serve(1, 2);
        repeat (2) tick();

        // Full FIFO: push collides with an FSM pop on the same edge.
        for (int k = 0; k < 5; k++) exp_q.push_back(8'h40 + 8'(k));
        push_seq(8'h40, 5);
        chk("coll_full", {31'd0, o_full}, 32'd1);
        chk("coll_no_ovf", {31'd0, o_overflow}, 32'd0);
        tick();
        i_tx_done_tick = 1'b1;
        tick();
        i_tx_done_tick = 1'b0;
        i_valid = 1'b1; i_result = 8'h45;
        tick();
        i_valid = 1'b0;
        done_count++;
        chk_outs("coll_pop_drop", {1'b1, 8'h41, 1'b1, 1'b0, 1'b1});
        exp_q.push_back(8'h46);
        i_valid = 1'b1; i_result = 8'h46;
        tick();
        i_valid = 1'b0;
        chk("coll_refull", {31'd0, o_full}, 32'd1);
        serve(5, 2);
        repeat (3) tick();
        chk_outs("coll_end", {1'b0, 8'h46, 1'b0, 1'b0, 1'b1});

        chk("total_starts", start_count, 17);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
